// File: rtl/keypad_emulator.sv
// Switch-side model of a 4x4 active-low matrix keypad: replays key-press commands with
// contact bounce, a stable hold and an inter-press gap, sensed through the scanner's columns.
module keypad_emulator #(
    parameter int unsigned BOUNCE_PERIOD  = 4,
    parameter int unsigned BOUNCE_TOGGLES = 6,
    parameter int unsigned HOLD_CYCLES    = 64,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_column,
    output logic [3:0] keypad_row,
    input  logic       press_valid,
    input  logic [3:0] press_key,
    output logic       press_ready,
    output logic       key_down,
    output logic       done_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned PerW     = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int unsigned TogW     = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
    localparam int unsigned DwellMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned DwW      = (DwellMax > 1) ? $clog2(DwellMax) : 1;

    localparam logic [PerW-1:0] PerLast  = PerW'(BOUNCE_PERIOD - 1);
    localparam logic [TogW-1:0] TogLast  = TogW'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);
    localparam logic [DwW-1:0]  HoldLast = DwW'(HOLD_CYCLES - 1);
    localparam logic [DwW-1:0]  GapLast  = DwW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit              HasBounce = (BOUNCE_TOGGLES != 0);
    localparam bit              HasGap    = (GAP_CYCLES != 0);

    typedef enum logic [2:0] {
        StIdle,
        StPressBounce,
        StHold,
        StReleaseBounce,
        StGap
    } state_e;

    state_e          state_q;
    logic [3:0]      key_q;
    logic [PerW-1:0] per_q;
    logic [TogW-1:0] tog_q;
    logic [DwW-1:0]  dwell_q;

    assign press_ready = (state_q == StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            key_q       <= '0;
            per_q       <= '0;
            tog_q       <= '0;
            dwell_q     <= '0;
            key_down    <= 1'b0;
            done_pulse  <= 1'b0;
            press_count <= '0;
        end else begin
            done_pulse <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (press_valid) begin
                        key_q    <= press_key;
                        key_down <= 1'b1;
                        per_q    <= '0;
                        tog_q    <= '0;
                        dwell_q  <= '0;
                        state_q  <= HasBounce ? StPressBounce : StHold;
                    end
                end
                StPressBounce: begin
                    if (per_q == PerLast) begin
                        per_q <= '0;
                        if (tog_q == TogLast) begin
                            state_q  <= StHold;
                            key_down <= 1'b1;
                            dwell_q  <= '0;
                        end else begin
                            tog_q    <= tog_q + 1'b1;
                            key_down <= ~key_down;
                        end
                    end else begin
                        per_q <= per_q + 1'b1;
                    end
                end
                StHold: begin
                    if (dwell_q == HoldLast) begin
                        key_down <= 1'b0;
                        dwell_q  <= '0;
                        per_q    <= '0;
                        tog_q    <= '0;
                        if (HasBounce) begin
                            state_q <= StReleaseBounce;
                        end else if (HasGap) begin
                            state_q <= StGap;
                        end else begin
                            state_q     <= StIdle;
                            done_pulse  <= 1'b1;
                            press_count <= press_count + 8'd1;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                StReleaseBounce: begin
                    if (per_q == PerLast) begin
                        per_q <= '0;
                        if (tog_q == TogLast) begin
                            key_down <= 1'b0;
                            dwell_q  <= '0;
                            if (HasGap) begin
                                state_q <= StGap;
                            end else begin
                                state_q     <= StIdle;
                                done_pulse  <= 1'b1;
                                press_count <= press_count + 8'd1;
                            end
                        end else begin
                            tog_q    <= tog_q + 1'b1;
                            key_down <= ~key_down;
                        end
                    end else begin
                        per_q <= per_q + 1'b1;
                    end
                end
                StGap: begin
                    if (dwell_q == GapLast) begin
                        state_q     <= StIdle;
                        done_pulse  <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Physical switch: the selected column reaches the latched row with no clock in between.
    always_comb begin
        keypad_row = 4'b1111;
        if (key_down && !keypad_column[key_q[3:2]]) begin
            keypad_row[key_q[1:0]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: per-cycle press profile scoreboard, row-mapping
// vector table, back-to-back commands, mid-press reset and a no-bounce counter-wrap instance.
module tb_keypad_emulator;

    localparam int BP = 4;
    localparam int BT = 6;
    localparam int HC = 64;
    localparam int GC = 16;
    localparam int PB = BT * BP;
    localparam int BUSY = 2 * PB + HC + GC;

    typedef struct packed {
        logic       kd;
        logic [3:0] row;
        logic       rdy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0] key;
        logic [3:0] col;
        logic [3:0] closed_row;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col, row, key;
    logic       valid, ready, kd, done;
    logic [7:0] cnt;
    logic [3:0] f_col, f_row, f_key;
    logic       f_valid, f_ready, f_kd, f_done;
    logic [7:0] f_cnt;

    int   total = 0;
    int   bad = 0;
    int   exp_count = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    always #5 clk = ~clk;

    keypad_emulator u_dut (
        .clk          (clk),
        .reset        (reset),
        .keypad_column(col),
        .keypad_row   (row),
        .press_valid  (valid),
        .press_key    (key),
        .press_ready  (ready),
        .key_down     (kd),
        .done_pulse   (done),
        .press_count  (cnt)
    );

    keypad_emulator #(
        .BOUNCE_PERIOD (1),
        .BOUNCE_TOGGLES(0),
        .HOLD_CYCLES   (3),
        .GAP_CYCLES    (0)
    ) u_fast (
        .clk          (clk),
        .reset        (reset),
        .keypad_column(f_col),
        .keypad_row   (f_row),
        .press_valid  (f_valid),
        .press_key    (f_key),
        .press_ready  (f_ready),
        .key_down     (f_kd),
        .done_pulse   (f_done),
        .press_count  (f_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Contact profile derived from the documented phase timing, o = cycles after acceptance.
    function automatic logic exp_kd(input int o);
        if (o <= PB) return ((o - 1) / BP) % 2 == 0;
        if (o <= PB + HC) return 1'b1;
        if (o <= 2 * PB + HC) return ((o - PB - HC - 1) / BP) % 2 == 1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("key_down", {31'd0, kd}, {31'd0, mon_e.kd});
            chk("keypad_row", {28'd0, row}, {28'd0, mon_e.row});
            chk("press_ready", {31'd0, ready}, {31'd0, mon_e.rdy});
            chk("done_pulse", {31'd0, done}, {31'd0, mon_e.done});
            chk("press_count", {24'd0, cnt}, {24'd0, mon_e.cnt});
        end
    end

    task automatic run_press(input logic [3:0] k, input logic [3:0] c, input logic [3:0] crow);
        exp_t e;
        int   n;
        @(posedge clk) #1;
        for (n = 0; n < 20 && !ready; n++) @(posedge clk) #1;
        chk("ready_wait", {31'd0, ready}, 32'd1);
        col   = c;
        key   = k;
        valid = 1'b1;
        @(posedge clk) #1;
        valid = 1'b0;
        for (int o = 1; o <= BUSY + 1; o++) begin
            e.kd   = exp_kd(o);
            e.row  = e.kd ? crow : 4'b1111;
            e.rdy  = (o == BUSY + 1);
            e.done = (o == BUSY + 1);
            e.cnt  = 8'(exp_count + ((o == BUSY + 1) ? 1 : 0));
            sb.push_back(e);
        end
        exp_count = exp_count + 1;
        for (n = 0; n < BUSY + 20 && sb.size() > 0; n++) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        int busy_bad;
        int fdone;

        vecs[0] = '{key: 4'b0110, col: 4'b1101, closed_row: 4'b1011};
        vecs[1] = '{key: 4'b0110, col: 4'b1110, closed_row: 4'b1111};
        vecs[2] = '{key: 4'b0110, col: 4'b0000, closed_row: 4'b1011};
        vecs[3] = '{key: 4'b1111, col: 4'b0111, closed_row: 4'b0111};
        vecs[4] = '{key: 4'b1111, col: 4'b1000, closed_row: 4'b1111};
        vecs[5] = '{key: 4'b0000, col: 4'b1110, closed_row: 4'b1110};
        vecs[6] = '{key: 4'b1001, col: 4'b1011, closed_row: 4'b1101};
        vecs[7] = '{key: 4'b1001, col: 4'b0100, closed_row: 4'b1111};
        vecs[8] = '{key: 4'b0011, col: 4'b0101, closed_row: 4'b1111};
        vecs[9] = '{key: 4'b0011, col: 4'b1010, closed_row: 4'b0111};

        reset = 1'b0; col = 4'b0000; key = 4'b0000; valid = 1'b0;
        f_col = 4'b0000; f_key = 4'b0000; f_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row", {28'd0, row}, 32'hF);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_count", {24'd0, cnt}, 32'd0);
        chk("rst_key_down", {31'd0, kd}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_row", {28'd0, row}, 32'hF);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);

        // Reset in the middle of the hold phase.
        @(posedge clk) #1;
        col = 4'b1101; key = 4'b0110; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (49) @(posedge clk);
        #2;
        chk("midhold_kd", {31'd0, kd}, 32'd1);
        chk("midhold_row", {28'd0, row}, 32'hB);
        reset = 1'b0;
        #1;
        chk("abort_kd", {31'd0, kd}, 32'd0);
        chk("abort_row", {28'd0, row}, 32'hF);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_count", {24'd0, cnt}, 32'd0);
        @(negedge clk) reset = 1'b1;

        foreach (vecs[i]) run_press(vecs[i].key, vecs[i].col, vecs[i].closed_row);

        // Back-to-back with press_valid held high across the busy period.
        @(posedge clk) #1;
        col = 4'b0000; key = 4'b0000; valid = 1'b1;
        chk("b2b_ready0", {31'd0, ready}, 32'd1);
        @(posedge clk) #1;
        key = 4'b1111;
        busy_bad = 0;
        for (int o = 1; o <= BUSY; o++) begin
            @(negedge clk);
            if (ready || done) busy_bad++;
            if (o == 30) chk("b2b_row_k0", {28'd0, row}, 32'hE);
        end
        chk("b2b_busy1", busy_bad, 32'd0);
        @(negedge clk);
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_ready1", {31'd0, ready}, 32'd1);
        chk("b2b_count1", {24'd0, cnt}, 32'(exp_count + 1));
        @(posedge clk) #1;
        valid = 1'b0;
        busy_bad = 0;
        for (int o = 1; o <= BUSY; o++) begin
            @(negedge clk);
            if (ready || done) busy_bad++;
            if (o == 30) chk("b2b_row_kf", {28'd0, row}, 32'h7);
        end
        chk("b2b_busy2", busy_bad, 32'd0);
        @(negedge clk);
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_count2", {24'd0, cnt}, 32'(exp_count + 2));
        exp_count = exp_count + 2;

        // No-bounce, no-gap instance: three-cycle hold, then counter wrap.
        @(posedge clk) #1;
        f_valid = 1'b1;
        @(posedge clk) #1;
        f_valid = 1'b0;
        for (int o = 1; o <= 4; o++) begin
            @(negedge clk);
            chk("fast_kd", {31'd0, f_kd}, {31'd0, (o <= 3)});
            chk("fast_done", {31'd0, f_done}, {31'd0, (o == 4)});
            if (o == 1) chk("fast_row", {28'd0, f_row}, 32'hE);
        end
        chk("fast_count1", {24'd0, f_cnt}, 32'd1);
        @(posedge clk) #1;
        f_valid = 1'b1;
        fdone = 0;
        for (int n = 0; n < 3000 && fdone < 255; n++) begin
            @(negedge clk);
            if (f_done) begin
                fdone++;
                if (fdone == 254) chk("fast_count255", {24'd0, f_cnt}, 32'd255);
            end
        end
        chk("fast_presses", fdone, 32'd255);
        chk("fast_wrap", {24'd0, f_cnt}, 32'd0);
        f_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
